// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory.
// Lane count is derived from the word width; the enums name access sizes and clear states.
package dmem_pkg;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    function automatic int LANES(input int b);
        return b / 8;
    endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the datapath and data_memory_sized.
// The master drives requests; the slave (the memory) returns load data and status strobes.
interface data_memory_sized_if #(
    parameter int B = 16,
    parameter int W = 11
);
    logic         Wr;
    logic         Rd;
    logic         Size;
    logic         Unsigned;
    logic [W-1:0] Addr;
    logic [B-1:0] In_Data;
    logic [B-1:0] Out_Data;
    logic         Rd_Valid;
    logic         Err;
    logic         Busy;

    modport master (
        output Wr, Rd, Size, Unsigned, Addr, In_Data,
        input  Out_Data, Rd_Valid, Err, Busy
    );

    modport slave (
        input  Wr, Rd, Size, Unsigned, Addr, In_Data,
        output Out_Data, Rd_Valid, Err, Busy
    );
endinterface

// File: rtl/dmem_array.sv
// Plain word-organised RAM with per-byte-lane write enables and a registered read port.
// A read of the word being written returns the pre-write contents.
module dmem_array #(
    parameter int B  = 16,
    parameter int L  = 2,
    parameter int AW = 10
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [L-1:0]  we,
    input  logic [AW-1:0] waddr,
    input  logic [B-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [B-1:0]  rdata
);
    localparam int DEPTH = 2**AW;

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (we[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Only the output register is reset; the array itself has no reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte/word data memory with sign/zero-extended byte loads and misalignment detection.
// Define DMEM_CLEAR_EN to build the post-reset clear engine that zeroes the array.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int B = 16,
    parameter int W = 11
)(
    input  logic               clk,
    input  logic               rst,
    data_memory_sized_if.slave bus
);
    localparam int L     = LANES(B);
    localparam int LB    = $clog2(L);
    localparam int AW    = W - LB;
    localparam int DEPTH = 2**AW;

    logic [LB-1:0] lane;
    logic [AW-1:0] word;
    logic          misaligned;
    logic          accept;
    logic          do_wr;
    logic          do_rd;
    logic          clr_active;
    logic [AW-1:0] clr_addr;

    logic [L-1:0]  we;
    logic [AW-1:0] waddr;
    logic [B-1:0]  wdata;
    logic [B-1:0]  raw;

    logic [LB-1:0] lane_q;
    size_t         size_q;
    logic          unsigned_q;
    logic          rd_valid_q;
    logic          err_q;
    logic [7:0]    lane_byte;
    logic [B-1:0]  out_data;

    assign lane       = bus.Addr[LB-1:0];
    assign word       = bus.Addr[W-1:LB];
    assign misaligned = (size_t'(bus.Size) == SZ_WORD) && (lane != '0);
    assign accept     = !clr_active;
    assign do_wr      = accept && bus.Wr && !misaligned;
    assign do_rd      = accept && bus.Rd && !misaligned;

`ifdef DMEM_CLEAR_EN
    localparam int CW = AW + 1;

    clr_state_t    state;
    clr_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // One word per cycle; the extra counter bit keeps the terminal compare from wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLEAR: begin
                cnt_next = cnt + CW'(1);
                if (cnt == CW'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign clr_active = (state == CLEAR);
    assign clr_addr   = cnt[AW-1:0];
`else
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
`endif

    // The clear sweep owns the write port while active; otherwise stores are lane-decoded.
    always_comb begin
        we    = '0;
        waddr = word;
        wdata = '0;
        if (clr_active) begin
            we    = '1;
            waddr = clr_addr;
            wdata = '0;
        end else if (do_wr) begin
            if (size_t'(bus.Size) == SZ_WORD) begin
                we    = '1;
                wdata = bus.In_Data;
            end else begin
                we    = L'(1) << lane;
                wdata = {L{bus.In_Data[7:0]}};
            end
        end
    end

    dmem_array #(
        .B  (B),
        .L  (L),
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (do_rd),
        .raddr (word),
        .rdata (raw)
    );

    // Load formatting controls are captured with the read so Out_Data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= do_rd;
            err_q      <= accept && misaligned && (bus.Wr || bus.Rd);
            if (do_rd) begin
                lane_q     <= lane;
                size_q     <= size_t'(bus.Size);
                unsigned_q <= bus.Unsigned;
            end
        end
    end

    always_comb begin
        lane_byte = raw[{lane_q, 3'b000} +: 8];
        if (size_q == SZ_WORD) begin
            out_data = raw;
        end else begin
            out_data = {{(B-8){lane_byte[7] & ~unsigned_q}}, lane_byte};
        end
    end

    assign bus.Out_Data = out_data;
    assign bus.Rd_Valid = rd_valid_q;
    assign bus.Err      = err_q;
    assign bus.Busy     = clr_active;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized using a byte-addressed reference model.
// Covers reset, clear sweep (when DMEM_CLEAR_EN is defined), directed cases and random traffic.
module tb_data_memory_sized;
    localparam int B     = 16;
    localparam int W     = 11;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_memory_sized_if #(.B(B), .W(W)) bus();

    data_memory_sized #(.B(B), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  memB [2**W];
    logic [15:0] expOut;
    logic        expBusy;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic size,
                                 input logic uns, input logic [10:0] addr,
                                 input logic [15:0] data);
        bus.Wr       = wr;
        bus.Rd       = rd;
        bus.Size     = size;
        bus.Unsigned = uns;
        bus.Addr     = addr;
        bus.In_Data  = data;
        @(posedge clk);
        #1;
        bus.Wr = 1'b0;
        bus.Rd = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic expErr);
        check({tag, ".valid"}, {15'b0, bus.Rd_Valid}, {15'b0, expValid});
        check({tag, ".err"},   {15'b0, bus.Err},      {15'b0, expErr});
        check({tag, ".busy"},  {15'b0, bus.Busy},     {15'b0, expBusy});
        check({tag, ".data"},  bus.Out_Data,          expOut);
    endtask

    // Model: memory is a flat byte array, little-endian, words at even byte addresses.
    task automatic doOp(input string tag, input logic wr, input logic rd, input logic size,
                        input logic uns, input logic [10:0] addr, input logic [15:0] data);
        logic v;
        logic e;
        v = 1'b0;
        e = 1'b0;
        if (!expBusy) begin
            if (size && addr[0]) begin
                e = wr || rd;
            end else begin
                if (rd) begin
                    v = 1'b1;
                    if (size)
                        expOut = {memB[addr + 1], memB[addr]};
                    else if (uns)
                        expOut = {8'h00, memB[addr]};
                    else
                        expOut = {{8{memB[addr][7]}}, memB[addr]};
                end
                if (wr) begin
                    memB[addr] = data[7:0];
                    if (size) memB[addr + 1] = data[15:8];
                end
            end
        end
        applyStimulus(wr, rd, size, uns, addr, data);
        checkOutput(tag, v, e);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [10:0] a;

        bus.Wr = 1'b0; bus.Rd = 1'b0; bus.Size = 1'b0; bus.Unsigned = 1'b0;
        bus.Addr = '0; bus.In_Data = '0;
        expOut = 16'h0000;

        #12;
        check("reset.data",  bus.Out_Data, 16'h0000);
        check("reset.valid", {15'b0, bus.Rd_Valid}, 16'h0000);
        check("reset.err",   {15'b0, bus.Err}, 16'h0000);
`ifdef DMEM_CLEAR_EN
        expBusy = 1'b1;
        check("reset.busy", {15'b0, bus.Busy}, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b0;

        // Let the sweep run partway, then restart it with reset.
        repeat (500) begin
            @(posedge clk); #1;
        end
        check("midclear.busy", {15'b0, bus.Busy}, 16'h0001);
        rst = 1'b1;
        #2;
        check("midclear.rst.data", bus.Out_Data, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        doOp("busy.wrrd", 1'b1, 1'b1, 1'b1, 1'b0, 11'h040, 16'hBEEF);
        doOp("busy.misrd", 1'b0, 1'b1, 1'b1, 1'b0, 11'h041, 16'h0000);
        n = 2;
        while (bus.Busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear.length", 16'(n), 16'(DEPTH));
        expBusy = 1'b0;
        for (int i = 0; i < 2**W; i++) memB[i] = 8'h00;
        doOp("clear.rd7fe", 1'b0, 1'b1, 1'b1, 1'b0, 11'h7FE, 16'h0000);
        check("clear.rd7fe.const", bus.Out_Data, 16'h0000);
        doOp("clear.rd040", 1'b0, 1'b1, 1'b1, 1'b0, 11'h040, 16'h0000);
`else
        expBusy = 1'b0;
        check("reset.busy", {15'b0, bus.Busy}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        doOp("wr004", 1'b1, 1'b0, 1'b1, 1'b0, 11'h004, 16'h0F0F);
        doOp("rd004", 1'b0, 1'b1, 1'b1, 1'b0, 11'h004, 16'h0000);
        check("rd004.const", bus.Out_Data, 16'h0F0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        checkOutput("idle1", 1'b0, 1'b0);

        doOp("wr010", 1'b1, 1'b0, 1'b1, 1'b0, 11'h010, 16'h1234);
        doOp("wrb011", 1'b1, 1'b0, 1'b0, 1'b0, 11'h011, 16'h0080);
        doOp("rd010", 1'b0, 1'b1, 1'b1, 1'b0, 11'h010, 16'h0000);
        check("rd010.const", bus.Out_Data, 16'h8034);
        doOp("rdb011s", 1'b0, 1'b1, 1'b0, 1'b0, 11'h011, 16'h0000);
        check("rdb011s.const", bus.Out_Data, 16'hFF80);
        doOp("rdb011u", 1'b0, 1'b1, 1'b0, 1'b1, 11'h011, 16'h0000);
        check("rdb011u.const", bus.Out_Data, 16'h0080);

        doOp("miswr", 1'b1, 1'b0, 1'b1, 1'b0, 11'h011, 16'hAAAA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        checkOutput("idle2", 1'b0, 1'b0);
        doOp("rd010b", 1'b0, 1'b1, 1'b1, 1'b0, 11'h010, 16'h0000);
        check("rd010b.const", bus.Out_Data, 16'h8034);
        doOp("misrd", 1'b0, 1'b1, 1'b1, 1'b0, 11'h011, 16'h0000);
        check("misrd.held", bus.Out_Data, 16'h8034);
        doOp("miswrrd", 1'b1, 1'b1, 1'b1, 1'b0, 11'h013, 16'h5555);

        doOp("wr020", 1'b1, 1'b0, 1'b1, 1'b0, 11'h020, 16'h1111);
        doOp("wrrd020", 1'b1, 1'b1, 1'b1, 1'b0, 11'h020, 16'h2222);
        check("wrrd020.const", bus.Out_Data, 16'h1111);
        doOp("rd020", 1'b0, 1'b1, 1'b1, 1'b0, 11'h020, 16'h0000);
        check("rd020.const", bus.Out_Data, 16'h2222);

        for (int i = 0; i < 32; i++) begin
            a = 11'(11'h100 + 2 * i);
            doOp("init", 1'b1, 1'b0, 1'b1, 1'b0, a, 16'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            a = 11'(11'h100 + $urandom_range(0, 63));
            doOp("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        rst = 1'b1;
        #2;
        check("rst2.data",  bus.Out_Data, 16'h0000);
        check("rst2.valid", {15'b0, bus.Rd_Valid}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
